axi_tdd_ng_counter: RTL and testbench

AXI_TDD_NG_COUNTER -- requirements
Module: axi_tdd_ng_counter

---
 rtl/axi_tdd_ng_counter.sv | 153 +++++++++++++++
 tb/tb_axi_tdd_ng_counter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/axi_tdd_ng_counter.sv
// TDD frame counter: after a sync pulse, waits a startup delay, then runs
// a burst of frames of programmable length and reports frame timing.
// Ports:
//   clk, resetn          - clock, async active-low reset
//   tdd_enable           - level enable; low forces IDLE
//   tdd_sync             - single-cycle sync pulse
//   tdd_sync_rst         - sync in RUNNING restarts the frame
//   tdd_startup_delay    - cycles from sync to first frame
//   tdd_frame_length     - cycles per frame (0 behaves as 1)
//   tdd_burst_count      - frames per burst (0 = infinite)
//   tdd_counter          - current frame/delay counter
//   tdd_cstate           - state: IDLE=0 ARMED=1 WAITING=2 RUNNING=3 DONE=4
//   tdd_tstart           - RUNNING and counter == 0
//   tdd_endof_frame      - RUNNING and counter == frame_length-1
//   tdd_running          - RUNNING
module axi_tdd_ng_counter #(
  parameter int unsigned REGISTER_WIDTH    = 32,
  parameter int unsigned BURST_COUNT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         tdd_enable,
  input  logic                         tdd_sync,
  input  logic                         tdd_sync_rst,
  input  logic [REGISTER_WIDTH-1:0]    tdd_startup_delay,
  input  logic [REGISTER_WIDTH-1:0]    tdd_frame_length,
  input  logic [BURST_COUNT_WIDTH-1:0] tdd_burst_count,
  output logic [REGISTER_WIDTH-1:0]    tdd_counter,
  output logic [2:0]                   tdd_cstate,
  output logic                         tdd_tstart,
  output logic                         tdd_endof_frame,
  output logic                         tdd_running
);

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    WAITING = 3'd2,
    RUNNING = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                       state, state_nxt;
  logic [REGISTER_WIDTH-1:0]    counter, counter_nxt;
  logic [BURST_COUNT_WIDTH-1:0] tally, tally_nxt;
  logic                         tstart_nxt, eof_nxt, running_nxt;
  logic [REGISTER_WIDTH-1:0]    len_m1;
  logic [REGISTER_WIDTH-1:0]    delay_m1;
  logic [BURST_COUNT_WIDTH-1:0] tally_inc;

  // Last counter value of a frame; a zero length behaves as one.
  assign len_m1    = (tdd_frame_length == '0) ? '0
                                              : tdd_frame_length - REGISTER_WIDTH'(1);
  assign delay_m1  = tdd_startup_delay - REGISTER_WIDTH'(1);
  assign tally_inc = tally + BURST_COUNT_WIDTH'(1);

  // State, counter, tally and decoded outputs register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      counter         <= '0;
      tally           <= '0;
      tdd_tstart      <= 1'b0;
      tdd_endof_frame <= 1'b0;
      tdd_running     <= 1'b0;
    end else begin
      state           <= state_nxt;
      counter         <= counter_nxt;
      tally           <= tally_nxt;
      tdd_tstart      <= tstart_nxt;
      tdd_endof_frame <= eof_nxt;
      tdd_running     <= running_nxt;
    end
  end

  // Next-state, counter and tally.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    tally_nxt   = tally;
    if (!tdd_enable) begin
      state_nxt   = IDLE;
      counter_nxt = '0;
      tally_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt   = ARMED;
          counter_nxt = '0;
          tally_nxt   = '0;
        end
        ARMED: begin
          counter_nxt = '0;
          tally_nxt   = '0;
          if (tdd_sync) begin
            state_nxt = (tdd_startup_delay != '0) ? WAITING : RUNNING;
          end
        end
        WAITING: begin
          // Equality only: a delay lowered below the counter runs to wrap.
          if (counter == delay_m1) begin
            state_nxt   = RUNNING;
            counter_nxt = '0;
          end else begin
            counter_nxt = counter + REGISTER_WIDTH'(1);
          end
        end
        RUNNING: begin
          // Restart takes priority over a coincident frame wrap.
          if (tdd_sync && tdd_sync_rst) begin
            counter_nxt = '0;
            tally_nxt   = '0;
          end else if (counter == len_m1) begin
            counter_nxt = '0;
            if ((tdd_burst_count != '0) && (tally_inc == tdd_burst_count)) begin
              state_nxt = DONE;
            end else begin
              tally_nxt = tally_inc;
            end
          end else begin
            counter_nxt = counter + REGISTER_WIDTH'(1);
          end
        end
        DONE: begin
          counter_nxt = '0;
        end
        default: begin
          state_nxt   = IDLE;
          counter_nxt = '0;
          tally_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode from the next registered state so outputs line up with state.
  always_comb begin
    running_nxt = 1'b0;
    tstart_nxt  = 1'b0;
    eof_nxt     = 1'b0;
    if (state_nxt == RUNNING) begin
      running_nxt = 1'b1;
      tstart_nxt  = (counter_nxt == '0);
      eof_nxt     = (counter_nxt == len_m1);
    end
  end

  assign tdd_counter = counter;
  assign tdd_cstate  = state;

endmodule

// File: tb/tb_axi_tdd_ng_counter.sv
module tb_axi_tdd_ng_counter;

  localparam int unsigned RW = 32;
  localparam int unsigned BW = 32;

  logic          clk;
  logic          resetn;
  logic          tdd_enable;
  logic          tdd_sync;
  logic          tdd_sync_rst;
  logic [RW-1:0] tdd_startup_delay;
  logic [RW-1:0] tdd_frame_length;
  logic [BW-1:0] tdd_burst_count;
  logic [RW-1:0] tdd_counter;
  logic [2:0]    tdd_cstate;
  logic          tdd_tstart;
  logic          tdd_endof_frame;
  logic          tdd_running;

  axi_tdd_ng_counter #(.REGISTER_WIDTH(RW), .BURST_COUNT_WIDTH(BW)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .tdd_enable        (tdd_enable),
    .tdd_sync          (tdd_sync),
    .tdd_sync_rst      (tdd_sync_rst),
    .tdd_startup_delay (tdd_startup_delay),
    .tdd_frame_length  (tdd_frame_length),
    .tdd_burst_count   (tdd_burst_count),
    .tdd_counter       (tdd_counter),
    .tdd_cstate        (tdd_cstate),
    .tdd_tstart        (tdd_tstart),
    .tdd_endof_frame   (tdd_endof_frame),
    .tdd_running       (tdd_running)
  );

  typedef struct {
    int          tag;
    logic [2:0]  st;
    logic [31:0] cnt;
    logic        ts;
    logic        eof;
    logic        run;
  } exp_t;

  exp_t expq[$];
  int   tests  = 0;
  int   failed = 0;
  int   tag    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input exp_t e);
    tests++;
    if (tdd_cstate !== e.st || tdd_counter !== e.cnt || tdd_tstart !== e.ts ||
        tdd_endof_frame !== e.eof || tdd_running !== e.run) begin
      failed++;
      $display("FAIL step%0d: got st=%0d cnt=%0d ts=%b eof=%b run=%b, want st=%0d cnt=%0d ts=%b eof=%b run=%b",
               e.tag, tdd_cstate, tdd_counter, tdd_tstart, tdd_endof_frame, tdd_running,
               e.st, e.cnt, e.ts, e.eof, e.run);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (expq.size() > 0) check(expq.pop_front());
  end

  function automatic exp_t mk(input int st, input int cnt, input bit ts, input bit eof);
    exp_t e;
    e.tag = tag;
    e.st  = 3'(st);
    e.cnt = 32'(cnt);
    e.ts  = ts;
    e.eof = eof;
    e.run = (st == 3);
    return e;
  endfunction

  // Drive inputs for one cycle and queue the state expected after the edge.
  task automatic cyc(input bit en, input bit sy, input bit srst,
                     input int st, input int cnt, input bit ts, input bit eof);
    tdd_enable   = en;
    tdd_sync     = sy;
    tdd_sync_rst = srst;
    tag++;
    expq.push_back(mk(st, cnt, ts, eof));
    @(posedge clk);
    #2;
  endtask

  initial begin
    resetn            = 1'b0;
    tdd_enable        = 1'b0;
    tdd_sync          = 1'b0;
    tdd_sync_rst      = 1'b0;
    tdd_startup_delay = 32'd3;
    tdd_frame_length  = 32'd5;
    tdd_burst_count   = 32'd2;
    #2;
    check(mk(0, 0, 0, 0));
    @(posedge clk);
    #2;
    resetn = 1'b1;

    // Basic burst: delay 3, length 5, two frames.
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 2, 0, 0, 0);
    cyc(1, 1, 0, 2, 1, 0, 0);   // sync ignored while waiting
    cyc(1, 0, 0, 2, 2, 0, 0);
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 5; c++)
        cyc(1, 0, 0, 3, c, c == 0, c == 4);
    cyc(1, 0, 0, 4, 0, 0, 0);
    cyc(1, 1, 0, 4, 0, 0, 0);   // no re-arm while enabled
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Zero delay, infinite burst, length 4; sync without restart ignored.
    tdd_startup_delay = 32'd0;
    tdd_burst_count   = 32'd0;
    tdd_frame_length  = 32'd4;
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 3, 0, 1, 0);
    for (int i = 1; i < 20; i++)
      cyc(1, i == 6, 0, 3, i % 4, (i % 4) == 0, (i % 4) == 3);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Restart collides with the frame wrap; burst of 1 must not complete.
    tdd_frame_length = 32'd8;
    tdd_burst_count  = 32'd1;
    cyc(1, 0, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 3, 0, 1, 0);
    for (int c = 1; c < 8; c++) cyc(1, 0, 1, 3, c, 0, c == 7);
    cyc(1, 1, 1, 3, 0, 1, 0);
    for (int c = 1; c < 8; c++) cyc(1, 0, 1, 3, c, 0, c == 7);
    cyc(1, 0, 1, 4, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Disable mid-run, sync while disabled has no effect, re-enable arms.
    tdd_burst_count = 32'd0;
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 3, 0, 1, 0);
    cyc(1, 0, 0, 3, 1, 0, 0);
    cyc(1, 0, 0, 3, 2, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);

    // Degenerate lengths 0 and 1 with a burst of 3.
    tdd_burst_count = 32'd3;
    for (int l = 0; l < 2; l++) begin
      tdd_frame_length = 32'(l);
      cyc(1, 1, 0, 3, 0, 1, 1);
      cyc(1, 0, 0, 3, 0, 1, 1);
      cyc(1, 0, 0, 3, 0, 1, 1);
      cyc(1, 0, 0, 4, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 0, 0, 0);
    end

    // Async reset between edges during RUNNING.
    tdd_frame_length = 32'd8;
    tdd_burst_count  = 32'd0;
    cyc(1, 1, 0, 3, 0, 1, 0);
    cyc(1, 0, 0, 3, 1, 0, 0);
    #1;
    resetn = 1'b0;
    #1;
    tag++;
    check(mk(0, 0, 0, 0));
    @(posedge clk);
    #2;
    tag++;
    check(mk(0, 0, 0, 0));
    resetn = 1'b1;
    cyc(1, 0, 0, 1, 0, 0, 0);

    @(posedge clk);
    #3;
    if (expq.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d entries left, want 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
